// File: rtl/ethercat_dgram_parser.sv
// EtherCAT datagram parser: assembles MII nibbles into bytes, validates the Ethernet/EtherCAT
// headers, then walks each datagram header, payload and working counter for the FMMU.
module ethercat_dgram_parser #(
    parameter logic [15:0] ETHERTYPE  = 16'h88A4,
    parameter logic [3:0]  ECAT_TYPE  = 4'h1,
    parameter logic [10:0] MAX_DG_LEN = 11'd1486
) (
    input  logic        rxc,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [3:0]  rx_data,
    output logic [7:0]  sub_command,
    output logic [7:0]  sub_index,
    output logic [31:0] sub_address,
    output logic [15:0] sub_len,
    output logic        sub_more,
    output logic        subdv,
    output logic        hdr_valid,
    output logic        data_valid,
    output logic [7:0]  data_byte,
    output logic        wkc_valid,
    output logic        wkc_hi,
    output logic        frame_err
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PRE  = 3'd1;
    localparam logic [2:0] ETH  = 3'd2;
    localparam logic [2:0] ECAT = 3'd3;
    localparam logic [2:0] DGH  = 3'd4;
    localparam logic [2:0] DAT  = 3'd5;
    localparam logic [2:0] WKC  = 3'd6;
    localparam logic [2:0] SKIP = 3'd7;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [7:0]  idx;
        logic [31:0] adr;
        logic [10:0] len;
        logic        more;
    } dg_hdr_t;

    dg_hdr_t     hdr;
    logic [2:0]  state;
    logic        hi_phase;
    logic [3:0]  lo_nib;
    logic [3:0]  prev_nib;
    logic [10:0] cnt;
    logic [10:0] rem;
    logic [7:0]  prev_byte;
    logic [1:0]  rst_sync;
    logic        rst_q;
    logic [7:0]  byte_in;
    logic        byte_stb;
    logic        dv_lost;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge rxc or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_q = rst_sync[1];

    assign byte_in  = {rx_data, lo_nib};
    assign byte_stb = rx_dv & hi_phase;
    assign dv_lost  = !rx_dv && (state inside {ETH, ECAT, DGH, DAT, WKC});

    always_ff @(posedge rxc or negedge rst_q) begin
        if (!rst_q) begin
            state       <= IDLE;
            hi_phase    <= 1'b0;
            lo_nib      <= '0;
            prev_nib    <= '0;
            cnt         <= '0;
            rem         <= '0;
            prev_byte   <= '0;
            hdr         <= '0;
            sub_command <= '0;
            sub_index   <= '0;
            sub_address <= '0;
            sub_len     <= '0;
            sub_more    <= 1'b0;
            subdv       <= 1'b0;
            hdr_valid   <= 1'b0;
            data_valid  <= 1'b0;
            data_byte   <= '0;
            wkc_valid   <= 1'b0;
            wkc_hi      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            hdr_valid  <= 1'b0;
            data_valid <= 1'b0;
            wkc_valid  <= 1'b0;
            wkc_hi     <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_dv) begin
                hi_phase <= ~hi_phase;
                if (!hi_phase) lo_nib <= rx_data;
            end
            // Saturating: an over-long datagram is caught by the header check, not by wrap.
            if (byte_stb && (state inside {DGH, DAT, WKC}) && rem != 11'd0)
                rem <= rem - 11'd1;

            if (dv_lost) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                subdv     <= 1'b0;
                hi_phase  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        hi_phase <= 1'b0;
                        prev_nib <= rx_data;
                        if (rx_dv) state <= PRE;
                    end
                    PRE: begin
                        if (!rx_dv) state <= IDLE;
                        else begin
                            prev_nib <= rx_data;
                            if (prev_nib == 4'h5 && rx_data == 4'hD) begin
                                state    <= ETH;
                                hi_phase <= 1'b0;
                                cnt      <= '0;
                            end
                        end
                    end
                    ETH: if (byte_stb) begin
                        cnt <= cnt + 11'd1;
                        if (cnt == 11'd12) prev_byte <= byte_in;
                        if (cnt == 11'd13) begin
                            cnt   <= '0;
                            state <= ({prev_byte, byte_in} == ETHERTYPE) ? ECAT : SKIP;
                        end
                    end
                    ECAT: if (byte_stb) begin
                        if (cnt == 11'd0) begin
                            prev_byte <= byte_in;
                            cnt       <= 11'd1;
                        end else begin
                            cnt <= '0;
                            if (byte_in[7:4] != ECAT_TYPE) begin
                                state     <= SKIP;
                                frame_err <= 1'b1;
                            end else begin
                                rem   <= {byte_in[2:0], prev_byte};
                                state <= DGH;
                            end
                        end
                    end
                    DGH: if (byte_stb) begin
                        cnt <= cnt + 11'd1;
                        case (cnt[3:0])
                            4'd0: hdr.cmd <= byte_in;
                            4'd1: hdr.idx <= byte_in;
                            4'd2, 4'd3, 4'd4, 4'd5: hdr.adr <= {byte_in, hdr.adr[31:8]};
                            4'd6: hdr.len[7:0] <= byte_in;
                            4'd7: begin
                                hdr.len[10:8] <= byte_in[2:0];
                                hdr.more      <= byte_in[7];
                            end
                            4'd9: begin
                                cnt <= '0;
                                // rem here is 9 below its value at the CMD byte: 12+LEN > rem0.
                                if (hdr.len > MAX_DG_LEN ||
                                    ({1'b0, hdr.len} + 12'd3) > {1'b0, rem}) begin
                                    state     <= SKIP;
                                    frame_err <= 1'b1;
                                end else begin
                                    sub_command <= hdr.cmd;
                                    sub_index   <= hdr.idx;
                                    sub_address <= hdr.adr;
                                    sub_len     <= {5'b0, hdr.len};
                                    sub_more    <= hdr.more;
                                    hdr_valid   <= 1'b1;
                                    if (hdr.len != 11'd0) begin
                                        state <= DAT;
                                        subdv <= 1'b1;
                                    end else begin
                                        state <= WKC;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                    DAT: if (byte_stb) begin
                        data_valid <= 1'b1;
                        data_byte  <= byte_in;
                        if (cnt == hdr.len - 11'd1) begin
                            cnt   <= '0;
                            state <= WKC;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                    end
                    WKC: begin
                        subdv <= 1'b0;
                        if (byte_stb) begin
                            wkc_valid <= 1'b1;
                            if (cnt[0]) begin
                                wkc_hi <= 1'b1;
                                cnt    <= '0;
                                state  <= hdr.more ? DGH : SKIP;
                            end else begin
                                cnt <= 11'd1;
                            end
                        end
                    end
                    default: begin
                        if (!rx_dv) begin
                            state     <= IDLE;
                            frame_err <= hi_phase;
                        end
                    end
                endcase
            end
        end
    end

endmodule
